// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage handshake between pipeline and the RV32M multiply/divide sequencer
// Ports (signals):
//   startE, funct3E, srcAE, srcBE, killE : pipeline -> sequencer (master drives)
//   stallMD, busy, resultValidE, resultE : sequencer -> pipeline (slave drives)
interface muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic            startE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] srcAE;
    logic [XLEN-1:0] srcBE;
    logic            killE;
    logic            stallMD;
    logic            busy;
    logic            resultValidE;
    logic [XLEN-1:0] resultE;

    modport master (
        output startE, funct3E, srcAE, srcBE, killE,
        input  stallMD, busy, resultValidE, resultE
    );

    modport slave (
        input  startE, funct3E, srcAE, srcBE, killE,
        output stallMD, busy, resultValidE, resultE
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative RV32M multiply/divide sequencer for the EX stage
// Ports:
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   md    : muldiv_ctrl_if.slave (op request/kill in; stallMD, busy, resultValidE, resultE out)
module muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_ctrl_if.slave   md
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
    logic [2:0]        op;
    logic              neg;       // negate the selected result half/quotient/remainder
    logic              busy_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;

    // ---------------- operand decode on the live EX inputs ----------------
    logic            a_signed, b_signed, sign_a, sign_b, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            is_div, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (md.funct3E)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                         begin a_signed = 1'b1; b_signed = 1'b0; end
            default:                        begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase
        sign_a = a_signed & md.srcAE[XLEN-1];
        sign_b = b_signed & md.srcBE[XLEN-1];
        mag_a  = sign_a ? -md.srcAE : md.srcAE;
        mag_b  = sign_b ? -md.srcBE : md.srcBE;
        // The remainder takes the dividend's sign; everything else takes sign(A)^sign(B).
        neg_in = (md.funct3E == 3'b110) ? sign_a : (sign_a ^ sign_b);

        is_div   = md.funct3E[2];
        div_zero = is_div & (md.srcBE == '0);
        div_ovf  = ((md.funct3E == 3'b100) || (md.funct3E == 3'b110)) &
                   (md.srcAE == INT_MIN) & (md.srcBE == ALL_ONE);
        special  = div_zero | div_ovf;

        // funct3E[1] separates REM/REMU from DIV/DIVU.
        special_res = '0;
        if (div_zero) special_res = md.funct3E[1] ? md.srcAE : ALL_ONE;
        else          special_res = md.funct3E[1] ? '0 : INT_MIN;
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};

        // Shift the next dividend bit into the partial remainder and trial-subtract.
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        // When div_ge holds, the true difference is below opb and fits in XLEN bits.
        div_diff  = div_shift[XLEN-1:0] - opb;
        div_next  = div_ge ? {div_diff,              acc[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0],   acc[XLEN-2:0], 1'b0};

        step = op[2] ? div_next : mul_next;
    end

    // ---------------- final result from the last step ----------------
    logic [2*XLEN-1:0] mul_p;
    logic [XLEN-1:0]   div_q, div_r;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        mul_p = neg ? -step : step;
        div_q = step[XLEN-1:0];
        div_r = step[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 final_res = mul_p[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = mul_p[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = neg ? -div_q : div_q;
            default:                final_res = neg ? -div_r : div_r;
        endcase
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            op       <= '0;
            neg      <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (md.killE) begin
                // Aborted op: drop back to IDLE, keep the last written result.
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (md.startE) begin
                            op     <= md.funct3E;
                            busy_q <= 1'b1;
                            if (special) begin
                                result_q <= special_res;
                                valid_q  <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                                opb   <= is_div ? mag_b : mag_a;
                                neg   <= neg_in;
                                cnt   <= '0;
                                state <= S_BUSY;
                            end
                        end
                    end
                    S_BUSY: begin
                        acc <= step;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(XLEN-1)) begin
                            result_q <= final_res;
                            valid_q  <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        // The finished instruction is still in EX; do not restart on its startE.
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Released in DONE so EX advances in the cycle the result is presented.
    assign md.stallMD      = rst_n & ~md.killE &
                             (((state == S_IDLE) & md.startE) | (state == S_BUSY));
    assign md.busy         = busy_q;
    assign md.resultValidE = valid_q;
    assign md.resultE      = result_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_ctrl_if #(.XLEN(32)) md();

    muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at the next negedge (T0), hold startE until the result shows,
    // and check stall length, result timing, result value and release.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_stall);
        int          stall_n = 0;
        int          done_t  = -1;
        logic [31:0] res     = '0;
        logic        stall_d = 1'b1;
        @(negedge clk);
        md.startE  = 1'b1;
        md.funct3E = f3;
        md.srcAE   = a;
        md.srcBE   = b;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (i == 1) begin
                md.srcAE = 32'h5a5a_1234;
                md.srcBE = 32'h0000_0003;
            end
            if (md.resultValidE) begin
                done_t  = i;
                res     = md.resultE;
                stall_d = md.stallMD;
                break;
            end
            if (md.stallMD) stall_n++;
        end
        chk({tag, " stall_cycles"}, stall_n, exp_stall);
        chk({tag, " done_cycle"}, done_t, exp_stall);
        chk({tag, " result"}, res, exp_res);
        chk({tag, " stall_in_done"}, {31'b0, stall_d}, 32'd0);
        @(negedge clk);
        md.startE = 1'b0;
        #1;
        chk({tag, " valid_one_cycle"}, {31'b0, md.resultValidE}, 32'd0);
        chk({tag, " busy_after"}, {31'b0, md.busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        logic        saw_valid;

        rst_n      = 1'b0;
        md.startE  = 1'b1;
        md.funct3E = 3'b000;
        md.srcAE   = 32'd7;
        md.srcBE   = 32'd9;
        md.killE   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", {31'b0, md.busy}, 32'd0);
        chk("reset valid", {31'b0, md.resultValidE}, 32'd0);
        chk("reset result", md.resultE, 32'd0);
        chk("reset stall", {31'b0, md.stallMD}, 32'd0);
        md.startE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7_m3",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu_m1_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_m1_m1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu_100_7",  3'b101, 32'd100,       32'd7,         32'd14,        33);
        run_op("remu_100_7",  3'b111, 32'd100,       32'd7,         32'd2,         33);
        run_op("divu_5_0",    3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_5_0",     3'b110, 32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Kill a DIV at T10; resultE must keep the REM overflow result (5 from rem_5_0 was
        // overwritten by div_ovf then rem_ovf -> 0), so write a non-zero one first.
        run_op("remu_100_7b", 3'b111, 32'd100,       32'd7,         32'd2,         33);
        prev      = 32'd2;
        saw_valid = 1'b0;
        @(negedge clk);
        md.startE  = 1'b1;
        md.funct3E = 3'b100;
        md.srcAE   = 32'd1000;
        md.srcBE   = 32'd3;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            #1;
            if (md.resultValidE) saw_valid = 1'b1;
        end
        chk("kill pre_stall", {31'b0, md.stallMD}, 32'd1);
        md.killE  = 1'b1;
        md.startE = 1'b0;
        #1;
        chk("kill stall_drop", {31'b0, md.stallMD}, 32'd0);
        @(negedge clk);
        md.killE = 1'b0;
        #1;
        if (md.resultValidE) saw_valid = 1'b1;
        chk("kill busy_T11", {31'b0, md.busy}, 32'd0);
        chk("kill no_valid", {31'b0, saw_valid}, 32'd0);
        chk("kill result_hold", md.resultE, prev);
        run_op("mul_3_4_after_kill", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Reset at T5 of a MUL.
        @(negedge clk);
        md.startE  = 1'b1;
        md.funct3E = 3'b000;
        md.srcAE   = 32'h0000_1234;
        md.srcBE   = 32'h0000_0010;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_mid busy_before", {31'b0, md.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid busy", {31'b0, md.busy}, 32'd0);
        chk("rst_mid stall", {31'b0, md.stallMD}, 32'd0);
        chk("rst_mid valid", {31'b0, md.resultValidE}, 32'd0);
        chk("rst_mid result", md.resultE, 32'd0);
        @(negedge clk);
        md.startE = 1'b0;
        rst_n     = 1'b1;
        run_op("mulhu_after_rst", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative sequencer for the RV32M multiply/divide unit in the EX stage.
- On an M-extension instruction in EX, it captures the operands and runs a 32-step shift-add multiply or a restoring divide.
- It raises stallMD to the hazard unit, which freezes F/D/E and bubbles M for the duration.
- It presents the result in the single cycle in which EX is released.

Parameters:
- XLEN, 32: operand/result width.
- CNT_W, 5: step counter width; log2(XLEN).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- startE  input  1  valid M-extension op in EX; held high while the instruction sits in EX.
- funct3E  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcAE  input  XLEN  rs1 operand, after forwarding.
- srcBE  input  XLEN  rs2 operand, after forwarding.
- killE  input  1  abort the in-flight op (trap/redirect).
- stallMD  output  1  stall request to the hazard unit; combinational.
- busy  output  1  state != IDLE; registered.
- resultValidE  output  1  resultE valid this cycle; registered.
- resultE  output  XLEN  rd write data; registered.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, cnt=0, all internal regs 0, busy=0, resultValidE=0, resultE=0. stallMD=0 while in reset.
- States:
  - IDLE: waiting for an op.
  - BUSY: iterating.
  - DONE: result presented.
- IDLE & startE & ~killE, normal path:
  - Capture |srcAE| and |srcBE| per the op signedness; capture funct3E.
  - Capture the negate flag for the result.
  - cnt<=0; next state BUSY.
- IDLE & startE & ~killE, special case:
  - Special cases are DIV*/REM* with srcBE==0, and DIV/REM with srcAE=0x80000000 and srcBE=0xFFFFFFFF.
  - Load resultE directly; next state DONE.
- BUSY: one step per cycle, cnt++. When cnt==XLEN-1, write the final result into resultE and go to DONE.
- DONE: resultValidE=1 for exactly one cycle; then IDLE unconditionally. startE is ignored in DONE, because the same instruction is still in EX.
- stallMD = (IDLE & startE & ~killE) | (BUSY & ~killE). stallMD=0 in DONE, so EX advances with resultE.
- Latency, normal path:
  - Start cycle T0, BUSY T1..T32, DONE T33.
  - stallMD is high T0..T32 (33 cycles).
- Latency, special case: stallMD high at T0 only; DONE at T1.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Multiply:
  - 2*XLEN-bit product of the magnitudes.
  - Negated when sign(A)^sign(B) and the op is signed.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide: restoring divide on the magnitudes.
  - Quotient negated if sign(A)^sign(B).
  - Remainder negated if sign(A).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero: quotient = all ones; remainder = srcAE.
- Overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- killE:
  - In any state: next state IDLE; resultValidE stays 0; stallMD forced 0 the same cycle.
  - resultE holds its previous value.
- Reset mid-operation: immediate return to IDLE with the reset values. No result is emitted.
- Back-to-back ops:
  - The next M op enters EX in the cycle after DONE.
  - It is accepted in IDLE; there are no dead cycles beyond DONE→IDLE.
- Operand capture: srcAE/srcBE are sampled only at T0. Later changes on the forwarding path are ignored.

Test Plan:
- MUL 7 × -3 (srcAE=7, srcBE=0xFFFFFFFD): stallMD high 33 cycles; resultValidE at T33; resultE=0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → resultE=0xFFFFFFFE. MULH of the same operands → resultE=0x00000000. MULHSU with srcAE=0xFFFFFFFF, srcBE=2 → resultE=0xFFFFFFFF.
- DIV -7/2 → resultE=0xFFFFFFFD. REM -7/2 → resultE=0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0: stallMD high 1 cycle; resultE=0xFFFFFFFF at T1. REM 5/0 → resultE=5. DIV 0x80000000/0xFFFFFFFF → 0x80000000, 1-cycle stall.
- killE at T10 of a DIV: stallMD drops at T10; busy=0 at T11; resultValidE never asserts. A new MUL 3×4 started at T12 → resultE=12 at T45.
- rst_n low at T5 of a MUL: busy, stallMD, resultValidE and resultE all 0 immediately. After release, IDLE accepts a new op.
